// File: rtl/sm_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// owner encoding and the latency-counter reload helper.
package sm_dmem_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arbState_t;

    // Owner encoding: which requester received the most recent grant
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // Latency counter width covers MEM_LAT-1 for MEM_LAT in 1..4
    localparam int LAT_CNT_W = 2;

    // Value loaded into the latency counter when the RAM strobe is issued
    function automatic logic [LAT_CNT_W-1:0] latReload(input int memLat);
        return LAT_CNT_W'(memLat - 1);
    endfunction

endpackage

// File: rtl/sm_dmem_arb_pick.sv
// Combinational 2-way picker for the data-memory arbiter.
// req[0] = CPU, req[1] = DBG; grant is one-hot with the same bit order.
// Build option: SM_DMEM_ARB_RR_EN selects round-robin on simultaneous
// requests (non-owner wins); otherwise the CPU has fixed priority.
module sm_dmem_arb_pick
    import sm_dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       lock,
    output logic [1:0] grant
);

    logic cpuEligible;

    // A CPU request is masked while DBG owns the last grant and holds the lock
    assign cpuEligible = req[0] & ~((owner == OWNER_DBG) & lock);

    // Choose one winner; contention resolution depends on the build option
    always_comb begin
        grant = 2'b00;
        if (cpuEligible && req[1]) begin
`ifdef SM_DMEM_ARB_RR_EN
            if (owner == OWNER_CPU) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
`else
            grant = 2'b01;
`endif
        end else if (cpuEligible) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/sm_dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the CPU
// load/store port and the debug/loader port. Each access walks
// IDLE -> ISSUE -> WAIT -> ACK and returns a one-cycle ack with read data.
// Build option: SM_DMEM_ARB_RR_EN (round-robin contention, see picker).
module sm_dmem_arbiter
    import sm_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  dbg_lock,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    arbState_t            state;
    logic [LAT_CNT_W-1:0] latCnt;
    logic [1:0]           grant;

    // Combinational winner selection from the live requests
    sm_dmem_arb_pick picker (
        .req   ({dbg_req, cpu_req}),
        .owner (owner),
        .lock  (dbg_lock),
        .grant (grant)
    );

    // Busy reflects any state other than IDLE
    assign busy = (state != ARB_IDLE);

    // Arbiter FSM: latches the winner's request into the RAM outputs, counts
    // the read latency, captures read data and pulses the winner's ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            latCnt    <= '0;
            owner     <= OWNER_CPU;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant[1]) begin
                        owner     <= OWNER_DBG;
                        mem_en    <= 1'b1;
                        mem_we    <= dbg_we;
                        mem_addr  <= dbg_addr;
                        mem_wdata <= dbg_wdata;
                        state     <= ARB_ISSUE;
                    end else if (grant[0]) begin
                        owner     <= OWNER_CPU;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    latCnt <= latReload(MEM_LAT);
                    state  <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (latCnt == '0) begin
                        if (owner == OWNER_DBG) begin
                            dbg_rdata <= mem_rdata;
                            dbg_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= ARB_ACK;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                ARB_ACK: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
